// File: rtl/word_byte_serializer.sv
// word_byte_serializer: captures selector words into a FIFO and streams each as five bytes, MSB first
module word_byte_serializer #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [39:0]                in_data,
  input  logic                       in_ready,
  input  logic [10:0]                in_tag,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       tx_first,
  output logic                       tx_last,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [39:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [39:0] sh;
  logic [2:0] idx;
  logic ready_q;
  logic [10:0] tag_q;
  logic new_word, hs, last_hs, full, pop, push, drop;
  assign new_word = in_ready & (~ready_q | (in_tag != tag_q));
  assign hs       = tx_valid & tx_ready;
  assign last_hs  = hs & (idx == 3'd4);
  assign full     = fifo_count == CW'(DEPTH);
  always_comb begin
    pop     = (fifo_count != '0) & ((state == IDLE) | last_hs);
    state_d = pop ? SEND : (last_hs ? IDLE : state);
  end
  // a full FIFO still accepts the push when the same edge frees a slot
  assign push = new_word & (~full | pop);
  assign drop = new_word & full & ~pop;
  always_ff @(posedge clk)
    if (!rst && push) mem[wptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      tag_q      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      sh         <= '0;
      idx        <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_first   <= 1'b0;
      tx_last    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      ready_q    <= in_ready;
      tag_q      <= in_tag;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= drop_count + DROP_W'(drop_count != '1);
      end
      if (pop) begin
        sh       <= mem[rptr];
        tx_data  <= mem[rptr][39:32];
        idx      <= '0;
        tx_valid <= 1'b1;
        tx_first <= 1'b1;
        tx_last  <= 1'b0;
        busy     <= 1'b1;
      end else if (last_hs) begin
        tx_valid <= 1'b0;
        tx_first <= 1'b0;
        tx_last  <= 1'b0;
        busy     <= 1'b0;
      end else if (hs) begin
        sh       <= sh << 8;
        tx_data  <= sh[31:24];
        idx      <= idx + 3'd1;
        tx_first <= 1'b0;
        tx_last  <= idx == 3'd3;
      end
    end
  end
endmodule

// File: tb/tb_word_byte_serializer.sv
// tb_word_byte_serializer: directed scenario tests for word_byte_serializer
module tb_word_byte_serializer;
  logic clk = 0, rst, in_ready, tx_ready;
  logic [39:0] in_data;
  logic [10:0] in_tag;
  logic [7:0] tx_data;
  logic tx_valid, tx_first, tx_last, busy, overflow;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;
  int checks = 0, passed = 0;
  logic [7:0] q[$];
  bit fq[$], lq[$];

  word_byte_serializer #(.DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ready(in_ready), .in_tag(in_tag),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_first(tx_first),
    .tx_last(tx_last), .fifo_count(fifo_count), .busy(busy), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    for (int c = 0; c < n; c++) begin
      if (tx_valid && tx_ready) begin
        q.push_back(tx_data);
        fq.push_back(tx_first);
        lq.push_back(tx_last);
      end
      tick();
    end
  endtask

  task automatic clear_q;
    q.delete();
    fq.delete();
    lq.delete();
  endtask

  task automatic test_reset;
    checks++; if ({tx_valid, tx_first, tx_last, busy} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {tx_valid, tx_first, tx_last, busy}); else passed++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_data got %h want 00", tx_data); else passed++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d want 0", fifo_count); else passed++;
    checks++; if ({overflow, drop_count} !== 9'd0) $display("FAIL reset_drop got %b/%0d want 0/0", overflow, drop_count); else passed++;
    rst = 0;
  endtask

  task automatic test_single;
    logic [7:0] exp [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    in_tag = 11'h001; in_data = 40'h12_3456_789A; in_ready = 1; tx_ready = 1;
    tick();
    checks++; if (tx_valid !== 1'b0) $display("FAIL single_early got %b want 0", tx_valid); else passed++;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({tx_valid, tx_data, tx_first, tx_last} !== {1'b1, exp[i], i == 0, i == 4})
        $display("FAIL single_byte%0d got v%b %h f%b l%b want v1 %h f%b l%b", i, tx_valid, tx_data, tx_first, tx_last, exp[i], i == 0, i == 4);
      else passed++;
      if (i == 0) in_ready = 0;
      tick();
    end
    checks++; if ({tx_valid, busy} !== 2'b00) $display("FAIL single_idle got v%b busy%b want 0 0", tx_valid, busy); else passed++;
  endtask

  task automatic test_held_switch;
    logic [7:0] exp [10] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    clear_q();
    in_tag = 11'h004; in_data = 40'h11_1111_1111; in_ready = 1; tx_ready = 1;
    collect(20);
    in_tag = 11'h400; in_data = 40'hAA_BBCC_DDEE;
    collect(20);
    in_ready = 0;
    tick();
    checks++; if (q.size() != 10) $display("FAIL held_count got %0d want 10", q.size()); else passed++;
    for (int i = 0; i < 10 && i < q.size(); i++) begin
      checks++; if (q[i] !== exp[i]) $display("FAIL held_byte%0d got %h want %h", i, q[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] pd;
    bit pf, pl, pv;
    pv = 0; pd = 0; pf = 0; pl = 0;
    clear_q();
    in_tag = 11'h002; in_data = 40'h01_0203_0405; in_ready = 1;
    for (int c = 0; c < 30; c++) begin
      tx_ready = (c % 3 == 0);
      if (c == 1) in_ready = 0;
      if (pv && tx_valid) begin
        checks++;
        if ({tx_data, tx_first, tx_last} !== {pd, pf, pl})
          $display("FAIL bp_stable got %h f%b l%b want %h f%b l%b", tx_data, tx_first, tx_last, pd, pf, pl);
        else passed++;
      end
      pd = tx_data; pf = tx_first; pl = tx_last; pv = tx_valid && !tx_ready;
      if (tx_valid && tx_ready) begin
        q.push_back(tx_data); fq.push_back(tx_first); lq.push_back(tx_last);
      end
      tick();
    end
    checks++; if (q.size() != 5) $display("FAIL bp_count got %0d want 5", q.size()); else passed++;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checks++;
      if ({q[i], fq[i], lq[i]} !== {8'(i + 1), i == 0, i == 4})
        $display("FAIL bp_byte%0d got %h f%b l%b want %h f%b l%b", i, q[i], fq[i], lq[i], 8'(i + 1), i == 0, i == 4);
      else passed++;
    end
  endtask

  task automatic test_overflow;
    clear_q();
    tx_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_tag = 11'(1 << i); in_data = {5{8'(8'h50 + i)}}; in_ready = 1;
      tick();
    end
    in_ready = 0;
    checks++; if (fifo_count !== 3'd4) $display("FAIL ovf_count got %0d want 4", fifo_count); else passed++;
    checks++; if ({overflow, drop_count} !== {1'b1, 8'd1}) $display("FAIL ovf_drop got %b/%0d want 1/1", overflow, drop_count); else passed++;
    checks++; if ({busy, tx_data} !== {1'b1, 8'h50}) $display("FAIL ovf_shift got busy%b %h want busy1 50", busy, tx_data); else passed++;
    tx_ready = 1;
    collect(35);
    checks++; if (q.size() != 25) $display("FAIL ovf_bytes got %0d want 25", q.size()); else passed++;
    for (int i = 0; i < 25 && i < q.size(); i++) begin
      checks++; if (q[i] !== 8'(8'h50 + i / 5)) $display("FAIL ovf_byte%0d got %h want %h", i, q[i], 8'(8'h50 + i / 5)); else passed++;
    end
    checks++; if ({fifo_count, overflow} !== {3'd0, 1'b1}) $display("FAIL ovf_after got %0d/%b want 0/1", fifo_count, overflow); else passed++;
  endtask

  task automatic test_full_push_pop;
    rst = 1; tx_ready = 0; in_ready = 0;
    tick();
    rst = 0;
    clear_q();
    for (int i = 0; i < 5; i++) begin
      in_tag = 11'(1 << i); in_data = {5{8'(8'h60 + i)}}; in_ready = 1;
      tick();
    end
    in_ready = 0; tx_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({tx_last, fifo_count} !== {1'b1, 3'd4}) $display("FAIL fpp_pre got l%b %0d want l1 4", tx_last, fifo_count); else passed++;
    in_tag = 11'h400; in_data = {5{8'h65}}; in_ready = 1;
    tick();
    in_ready = 0;
    checks++; if (fifo_count !== 3'd4) $display("FAIL fpp_count got %0d want 4", fifo_count); else passed++;
    checks++; if ({overflow, drop_count} !== 9'd0) $display("FAIL fpp_drop got %b/%0d want 0/0", overflow, drop_count); else passed++;
    checks++; if ({tx_first, tx_data} !== {1'b1, 8'h61}) $display("FAIL fpp_next got f%b %h want f1 61", tx_first, tx_data); else passed++;
    collect(30);
    checks++; if (q.size() != 25) $display("FAIL fpp_bytes got %0d want 25", q.size()); else passed++;
    for (int i = 0; i < 25 && i < q.size(); i++) begin
      checks++; if (q[i] !== 8'(8'h61 + i / 5)) $display("FAIL fpp_byte%0d got %h want %h", i, q[i], 8'(8'h61 + i / 5)); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [5] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
    clear_q();
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_tag = 11'(1 << i); in_data = {5{8'(8'h70 + i)}}; in_ready = 1;
      tick();
    end
    in_data = 40'h81_8283_8485;
    tick();
    tick();
    checks++; if ({tx_valid, fifo_count} !== {1'b1, 3'd2}) $display("FAIL rm_pre got v%b %0d want v1 2", tx_valid, fifo_count); else passed++;
    rst = 1;
    tick();
    checks++; if ({tx_valid, busy, fifo_count, drop_count} !== 13'd0) $display("FAIL rm_flush got v%b b%b %0d %0d want 0 0 0 0", tx_valid, busy, fifo_count, drop_count); else passed++;
    rst = 0;
    collect(20);
    in_ready = 0;
    checks++; if (q.size() != 5) $display("FAIL rm_bytes got %0d want 5", q.size()); else passed++;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      checks++;
      if ({q[i], fq[i], lq[i]} !== {exp[i], i == 0, i == 4})
        $display("FAIL rm_byte%0d got %h f%b l%b want %h f%b l%b", i, q[i], fq[i], lq[i], exp[i], i == 0, i == 4);
      else passed++;
    end
  endtask

  initial begin
    rst = 1; in_ready = 0; in_tag = 0; in_data = 0; tx_ready = 0;
    tick();
    tick();
    test_reset();
    tick();
    test_single();
    test_held_switch();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
Downstream consumer of the 11-way 40-bit selector stage. It captures each new 40-bit word the selector presents, using the selector's registered `out`/`ready` pair plus a tag. Captured words are buffered in a small FIFO. Each word is then emitted as five bytes, MSB first, on a valid/ready byte stream that feeds the UART/host link.

Parameters:
DEPTH, 4, FIFO depth in 40-bit words; power of two, >= 2
DROP_W, 8, width of saturating dropped-word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  40  selector output word
in_ready  in  1  selector ready flag (level, not pulse)
in_tag  in  11  one-hot source select, registered by the top level so it aligns with in_data/in_ready
tx_data  out  8  byte to link
tx_valid  out  1  tx_data valid
tx_ready  in  1  link accepts byte
tx_first  out  1  current byte is byte 0 (bits 39:32) of a word
tx_last  out  1  current byte is byte 4 (bits 7:0) of a word
fifo_count  out  $clog2(DEPTH)+1  words currently buffered
busy  out  1  serializer holds a word (state SEND)
overflow  out  1  sticky: a word was dropped
drop_count  out  DROP_W  dropped words, saturating

Behaviour:
- Reset values (registered, applied on clk edge with rst=1): tx_valid=0, tx_first=0, tx_last=0, tx_data=0, busy=0, overflow=0, drop_count=0, fifo_count=0, FIFO pointers=0, state=IDLE, byte index=0, ready_q=0, tag_q=0.
- Capture detect: ready_q and tag_q are registered copies of in_ready and in_tag, updated every cycle.
  - new_word = in_ready & (~ready_q | (in_tag != tag_q)).
  - A rising ready captures. A source switch while ready stays high also captures.
  - A ready held high with an unchanged tag captures nothing further.
- Push: on new_word, write in_data at the edge ending the detect cycle.
  - If the FIFO is full and no pop occurs that edge, the word is dropped: overflow<=1 (sticky until rst); drop_count increments and saturates at all-ones.
  - Push and pop on the same edge when full: the push is accepted and fifo_count is unchanged.
- FIFO: circular buffer, pointers wrap modulo DEPTH. fifo_count is exact. Read data comes directly from the array at the read pointer (no output register).
- State machine, two states:
  - IDLE: if fifo_count != 0, pop into shift word, idx<=0, go to SEND.
  - SEND: tx_valid=1. tx_data = word[39-8*idx -: 8]. tx_first=(idx==0). tx_last=(idx==4).
  - Handshake = tx_valid & tx_ready. Without a handshake, tx_data, tx_first and tx_last hold stable.
  - On handshake with idx<4: idx<=idx+1.
  - On handshake with idx==4: if the FIFO is non-empty, pop the next word, idx<=0, stay in SEND (back-to-back, no idle bubble). Otherwise go to IDLE and tx_valid<=0.
  - All tx_* outputs and busy are registered.
- Latency: with the FIFO empty and in IDLE, a word detected in cycle N is written at the end of N and loaded at the end of N+1. tx_valid and tx_first are high in cycle N+2.
- Throughput: 5 cycles per word when tx_ready is held high.
- Reset mid-frame: the frame is aborted and not resumed. The FIFO is flushed. ready_q is cleared, so an in_ready still high after reset is captured as a new word.
- in_data is sampled only in the detect cycle; later changes do not affect buffered words.

Test Plan:
- Single word: in_tag=0x001, in_ready 0->1 with in_data=0x12_3456_789A, tx_ready=1 -> tx_valid high two cycles later; bytes 0x12,0x34,0x56,0x78,0x9A on consecutive cycles; tx_first on 0x12 only, tx_last on 0x9A only; then IDLE, busy=0.
- Held ready / source switch: in_ready held high 20 cycles with in_tag=0x004; then in_tag->0x400 with in_data=0xAA_BBCC_DDEE while ready stays high -> exactly two words serialized, second is AA,BB,CC,DD,EE.
- Backpressure: tx_ready toggled 1,0,0,1,... during a word -> no byte lost or duplicated; tx_data and tx_first/tx_last stable while tx_ready=0.
- Overflow: tx_ready=0, inject 6 distinct words (DEPTH=4) -> 1 word in shift register, fifo_count=4, overflow=1, drop_count=1. Release tx_ready -> first 5 words emitted in order, 6th absent.
- Full push+pop: FIFO full; push lands on the same edge as the final-byte handshake -> word accepted, fifo_count stays 4, overflow stays 0.
- Reset mid-frame: rst pulsed after byte 2 with 2 words queued and in_ready high -> next cycle tx_valid=0, fifo_count=0, drop_count=0. First cycle after rst captures the current in_data, and it serializes from byte 0.
